col_reduce_cfg_ctrl: RTL and testbench

//   Configuration sequencer for the paired colorReduce datapath. Holds user-edited

---
 rtl/col_reduce_pkg.sv | 37 +++
 rtl/col_reduce_cfg_ctrl_shadow_bank.sv | 88 ++++++++
 rtl/col_reduce_cfg_ctrl.sv | 178 +++++++++++++++++
 tb/tb_col_reduce_cfg_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/col_reduce_pkg.sv
// ============================================================================
//  Module   : col_reduce_pkg
//  Purpose  : Shared types, sizes and helpers for the colorReduce config path.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package col_reduce_pkg;

    localparam int              NUM_SLOTS = 4;
    localparam int              SLOT_W    = 2;
    localparam int              VAL_W     = 3;
    localparam logic [VAL_W-1:0] VAL_MAX  = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PENDING = 3'd1,
        WRITE   = 3'd2,
        GAP     = 3'd3,
        SETTLE  = 3'd4
    } cfg_state_t;

    function automatic logic [SLOT_W-1:0] lowest_slot(input logic [NUM_SLOTS-1:0] mask);
        lowest_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mask[i]) lowest_slot = SLOT_W'(i);
        end
    endfunction

    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
        slot_onehot = '0;
        slot_onehot[slot] = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/col_reduce_cfg_ctrl_shadow_bank.sv
// ============================================================================
//  Module   : cfg_shadow_bank
//  Purpose  : User-edited shadow settings, dirty tracking and slot cursor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cfg_shadow_bank
    import col_reduce_pkg::*;
#(
    parameter logic [VAL_W-1:0] DEFAULT_VAL = 3'd4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            btn_next,
    input  logic                            btn_up,
    input  logic                            btn_down,
    input  logic                            btn_bright,
    input  logic [NUM_SLOTS-1:0]            clr_dirty,
    input  logic                            clr_bright_dirty,
    output logic [NUM_SLOTS-1:0][VAL_W-1:0] shadow,
    output logic [NUM_SLOTS-1:0]            dirty,
    output logic                            bright_flag,
    output logic                            bright_dirty,
    output logic [SLOT_W-1:0]               cur_sel,
    output logic [VAL_W-1:0]                cur_val
);

    logic [NUM_SLOTS-1:0][VAL_W-1:0] shadow_q, shadow_d;
    logic [NUM_SLOTS-1:0]            dirty_q, dirty_d;
    logic                            bright_q, bright_d;
    logic                            bdirty_q, bdirty_d;
    logic [SLOT_W-1:0]               sel_q, sel_d;

    // Clears are applied first so an edit in the same cycle re-marks the slot.
    always_comb begin
        shadow_d = shadow_q;
        dirty_d  = dirty_q & ~clr_dirty;
        bright_d = bright_q;
        bdirty_d = bdirty_q & ~clr_bright_dirty;
        sel_d    = sel_q;

        if (btn_up && !btn_down) begin
            if (shadow_q[sel_q] != VAL_MAX) begin
                shadow_d[sel_q] = shadow_q[sel_q] + VAL_W'(1);
                dirty_d[sel_q]  = 1'b1;
            end
        end else if (btn_down && !btn_up) begin
            if (shadow_q[sel_q] != '0) begin
                shadow_d[sel_q] = shadow_q[sel_q] - VAL_W'(1);
                dirty_d[sel_q]  = 1'b1;
            end
        end

        if (btn_bright) begin
            bright_d = ~bright_q;
            bdirty_d = 1'b1;
        end

        if (btn_next) sel_d = sel_q + SLOT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= {NUM_SLOTS{DEFAULT_VAL}};
            dirty_q  <= '0;
            bright_q <= 1'b0;
            bdirty_q <= 1'b0;
            sel_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
            bright_q <= bright_d;
            bdirty_q <= bdirty_d;
            sel_q    <= sel_d;
        end
    end

    assign shadow       = shadow_q;
    assign dirty        = dirty_q;
    assign bright_flag  = bright_q;
    assign bright_dirty = bdirty_q;
    assign cur_sel      = sel_q;
    assign cur_val      = shadow_q[sel_q];

endmodule

`default_nettype wire

// File: rtl/col_reduce_cfg_ctrl.sv
// ============================================================================
//  Module   : col_reduce_cfg_ctrl
//  Purpose  : Frame-aligned commit sequencer for colorReduce selector settings.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module col_reduce_cfg_ctrl
    import col_reduce_pkg::*;
#(
    parameter logic [VAL_W-1:0] DEFAULT_VAL   = 3'd4,
    parameter int               CHG_CYCLES    = 2,
    parameter int               GAP_CYCLES    = 1,
    parameter int               SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_next,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_bright,
    input  logic              btn_apply,
    input  logic              frame_end,
    output logic [SLOT_W-1:0] switch_sels,
    output logic [VAL_W-1:0]  switch_vals,
    output logic              change,
    output logic              brighter,
    output logic [SLOT_W-1:0] cur_sel,
    output logic [VAL_W-1:0]  cur_val,
    output logic              pending,
    output logic              cfg_busy
);

    localparam int MAX_CG  = (CHG_CYCLES > GAP_CYCLES) ? CHG_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX = (MAX_CG > SETTLE_CYCLES) ? MAX_CG : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [NUM_SLOTS-1:0][VAL_W-1:0] shadow;
    logic [NUM_SLOTS-1:0]            dirty;
    logic                            bright_flag;
    logic                            bright_dirty;
    logic [NUM_SLOTS-1:0]            clr_dirty;
    logic                            clr_bright_dirty;

    cfg_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0] commit_q, commit_d;
    logic [SLOT_W-1:0]   sels_q, sels_d;
    logic [VAL_W-1:0]    vals_q, vals_d;
    logic                brighter_q, brighter_d;

    logic [NUM_SLOTS-1:0] src_mask;
    logic [SLOT_W-1:0]    next_slot;
    logic [NUM_SLOTS-1:0] next_1h;

    cfg_shadow_bank #(
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_bank (
        .clk              (clk),
        .reset            (reset),
        .btn_next         (btn_next),
        .btn_up           (btn_up),
        .btn_down         (btn_down),
        .btn_bright       (btn_bright),
        .clr_dirty        (clr_dirty),
        .clr_bright_dirty (clr_bright_dirty),
        .shadow           (shadow),
        .dirty            (dirty),
        .bright_flag      (bright_flag),
        .bright_dirty     (bright_dirty),
        .cur_sel          (cur_sel),
        .cur_val          (cur_val)
    );

    // The first slot comes from the live dirty mask; later ones from the latched mask.
    assign src_mask  = (state_q == PENDING) ? dirty : commit_q;
    assign next_slot = lowest_slot(src_mask);
    assign next_1h   = slot_onehot(next_slot);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        commit_d         = commit_q;
        sels_d           = sels_q;
        vals_d           = vals_q;
        brighter_d       = brighter_q;
        clr_dirty        = '0;
        clr_bright_dirty = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (btn_apply && ((dirty != '0) || bright_dirty)) state_d = PENDING;
            end
            PENDING: begin
                if (frame_end) begin
                    cnt_d = '0;
                    if (bright_dirty) begin
                        brighter_d       = bright_flag;
                        clr_bright_dirty = 1'b1;
                    end
                    if (dirty != '0) begin
                        state_d   = WRITE;
                        sels_d    = next_slot;
                        vals_d    = shadow[next_slot];
                        clr_dirty = next_1h;
                        commit_d  = dirty & ~next_1h;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == CNT_W'(CHG_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (commit_q != '0) begin
                        state_d   = WRITE;
                        sels_d    = next_slot;
                        vals_d    = shadow[next_slot];
                        clr_dirty = next_1h;
                        commit_d  = commit_q & ~next_1h;
                    end else begin
                        state_d = SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            commit_q   <= '0;
            sels_q     <= '0;
            vals_q     <= '0;
            brighter_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            commit_q   <= commit_d;
            sels_q     <= sels_d;
            vals_q     <= vals_d;
            brighter_q <= brighter_d;
        end
    end

    assign switch_sels = sels_q;
    assign switch_vals = vals_q;
    assign change      = (state_q == WRITE);
    assign brighter    = brighter_q;
    assign pending     = (state_q == PENDING);
    assign cfg_busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_col_reduce_cfg_ctrl.sv
// ============================================================================
//  Module   : tb_col_reduce_cfg_ctrl
//  Purpose  : Self-checking bench for col_reduce_cfg_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_col_reduce_cfg_ctrl;

    localparam int C_CHG    = 2;
    localparam int C_GAP    = 1;
    localparam int C_SETTLE = 4;
    localparam int C_PER    = C_CHG + C_GAP;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       btn_bright = 1'b0, btn_apply = 1'b0, frame_end = 1'b0;
    logic [1:0] switch_sels, cur_sel;
    logic [2:0] switch_vals, cur_val;
    logic       change, brighter, pending, cfg_busy;

    int n_chk = 0;
    int n_fail = 0;

    col_reduce_cfg_ctrl #(
        .DEFAULT_VAL   (3'd4),
        .CHG_CYCLES    (C_CHG),
        .GAP_CYCLES    (C_GAP),
        .SETTLE_CYCLES (C_SETTLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_next    (btn_next),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_bright  (btn_bright),
        .btn_apply   (btn_apply),
        .frame_end   (frame_end),
        .switch_sels (switch_sels),
        .switch_vals (switch_vals),
        .change      (change),
        .brighter    (brighter),
        .cur_sel     (cur_sel),
        .cur_val     (cur_val),
        .pending     (pending),
        .cfg_busy    (cfg_busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_PEND = 1, M_COMMIT = 2;
    int m_sh[4];
    bit m_dirty[4];
    bit m_bsh, m_bdirty;
    int m_sel, m_mode, m_now, m_t0, m_tend, m_n;
    int m_slots[4];
    int m_sels, m_vals;
    bit m_bright;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i] = 4;
            m_dirty[i] = 1'b0;
        end
        m_bsh = 0; m_bdirty = 0; m_sel = 0; m_mode = M_IDLE;
        m_sels = 0; m_vals = 0; m_bright = 0; m_n = 0;
    endtask

    function automatic bit any_dirty();
        bit r = 0;
        for (int i = 0; i < 4; i++) r |= m_dirty[i];
        return r;
    endfunction

    // Commit plan: slot k occupies cycles t0+k*PER .. +CHG-1; idle again at t0+n*PER+SETTLE.
    task automatic model_edge();
        m_now++;
        if (m_mode == M_PEND && frame_end) begin
            m_n = 0;
            for (int s = 0; s < 4; s++) if (m_dirty[s]) begin m_slots[m_n] = s; m_n++; end
            m_t0 = m_now;
            m_tend = m_now + m_n * C_PER + C_SETTLE;
            if (m_bdirty) begin m_bright = m_bsh; m_bdirty = 0; end
            m_mode = M_COMMIT;
        end else if (m_mode == M_IDLE && btn_apply && (any_dirty() || m_bdirty)) begin
            m_mode = M_PEND;
        end
        if (m_mode == M_COMMIT) begin
            for (int k = 0; k < m_n; k++) begin
                if (m_now == m_t0 + k * C_PER) begin
                    m_sels = m_slots[k];
                    m_vals = m_sh[m_slots[k]];
                    m_dirty[m_slots[k]] = 0;
                end
            end
            if (m_now == m_tend) m_mode = M_IDLE;
        end
        if (btn_up && !btn_down) begin
            if (m_sh[m_sel] < 7) begin m_sh[m_sel]++; m_dirty[m_sel] = 1; end
        end else if (btn_down && !btn_up) begin
            if (m_sh[m_sel] > 0) begin m_sh[m_sel]--; m_dirty[m_sel] = 1; end
        end
        if (btn_bright) begin m_bsh = !m_bsh; m_bdirty = 1; end
        if (btn_next) m_sel = (m_sel + 1) % 4;
    endtask

    function automatic bit model_change();
        bit r = 0;
        if (m_mode == M_COMMIT)
            for (int k = 0; k < m_n; k++)
                if (m_now >= m_t0 + k * C_PER && m_now < m_t0 + k * C_PER + C_CHG) r = 1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, m_now);
        end
    endtask

    task automatic check_model();
        chk("cur_sel", 32'(cur_sel), 32'(m_sel));
        chk("cur_val", 32'(cur_val), 32'(m_sh[m_sel]));
        chk("change", 32'(change), 32'(model_change()));
        chk("switch_sels", 32'(switch_sels), 32'(m_sels));
        chk("switch_vals", 32'(switch_vals), 32'(m_vals));
        chk("brighter", 32'(brighter), 32'(m_bright));
        chk("pending", 32'(pending), 32'(m_mode == M_PEND));
        chk("cfg_busy", 32'(cfg_busy), 32'(m_mode != M_IDLE));
    endtask

    task automatic drive(input bit nx, input bit up, input bit dn, input bit br,
                         input bit ap, input bit fe);
        btn_next = nx; btn_up = up; btn_down = dn;
        btn_bright = br; btn_apply = ap; frame_end = fe;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin m_now++; model_reset(); end
        else model_edge();
        @(negedge clk);
        check_model();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit nx, up, dn, br, ap, fe;
        int e_sel, e_val, e_chg, e_sels, e_vals, e_busy, e_pend;
    } vec_t;

    function automatic vec_t mk(bit nx, bit up, bit dn, bit br, bit ap, bit fe,
                                int sel, int val, int chg, int sels, int vals,
                                int busy, int pend);
        vec_t v;
        v.nx = nx; v.up = up; v.dn = dn; v.br = br; v.ap = ap; v.fe = fe;
        v.e_sel = sel; v.e_val = val; v.e_chg = chg; v.e_sels = sels;
        v.e_vals = vals; v.e_busy = busy; v.e_pend = pend;
        return v;
    endfunction

    vec_t tbl[19];

    initial begin
        int found;
        tbl[0]  = mk(1,0,0,0,0,0, 1,4,0,0,0,0,0);
        tbl[1]  = mk(0,1,0,0,0,0, 1,5,0,0,0,0,0);
        tbl[2]  = mk(0,1,0,0,0,0, 1,6,0,0,0,0,0);
        tbl[3]  = mk(1,0,0,0,0,0, 2,4,0,0,0,0,0);
        tbl[4]  = mk(1,0,0,0,0,0, 3,4,0,0,0,0,0);
        tbl[5]  = mk(0,0,1,0,0,0, 3,3,0,0,0,0,0);
        tbl[6]  = mk(0,0,0,0,1,0, 3,3,0,0,0,1,1);
        tbl[7]  = mk(0,0,0,0,0,0, 3,3,0,0,0,1,1);
        tbl[8]  = mk(0,0,0,0,0,1, 3,3,1,1,6,1,0);
        tbl[9]  = mk(0,0,0,0,0,0, 3,3,1,1,6,1,0);
        tbl[10] = mk(0,0,0,0,0,0, 3,3,0,1,6,1,0);
        tbl[11] = mk(0,0,0,0,0,0, 3,3,1,3,3,1,0);
        tbl[12] = mk(0,0,0,0,0,0, 3,3,1,3,3,1,0);
        tbl[13] = mk(0,0,0,0,0,0, 3,3,0,3,3,1,0);
        for (int i = 14; i < 18; i++) tbl[i] = mk(0,0,0,0,0,0, 3,3,0,3,3,1,0);
        tbl[18] = mk(0,0,0,0,0,0, 3,3,0,3,3,0,0);

        m_now = 0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        reset = 1'b1;

        // Reset state over 10 idle cycles; walk the cursor once around.
        for (int i = 0; i < 10; i++) begin
            drive(i < 4, 0, 0, 0, 0, 0);
            tick();
            chk("rst_cur_val", 32'(cur_val), 32'd4);
            chk("rst_busy", 32'(cfg_busy), 32'd0);
            chk("rst_change", 32'(change), 32'd0);
            chk("rst_sels", 32'(switch_sels), 32'd0);
        end

        // Two-slot commit.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].nx, tbl[i].up, tbl[i].dn, tbl[i].br, tbl[i].ap, tbl[i].fe);
            tick();
            chk("tv_sel", 32'(cur_sel), 32'(tbl[i].e_sel));
            chk("tv_val", 32'(cur_val), 32'(tbl[i].e_val));
            chk("tv_change", 32'(change), 32'(tbl[i].e_chg));
            chk("tv_sels", 32'(switch_sels), 32'(tbl[i].e_sels));
            chk("tv_vals", 32'(switch_vals), 32'(tbl[i].e_vals));
            chk("tv_busy", 32'(cfg_busy), 32'(tbl[i].e_busy));
            chk("tv_pend", 32'(pending), 32'(tbl[i].e_pend));
        end

        // Apply with nothing dirty is ignored.
        drive(0, 0, 0, 0, 1, 0); tick();
        chk("clean_apply_busy", 32'(cfg_busy), 32'd0);
        drive(0, 0, 0, 0, 0, 1); tick();
        chk("clean_apply_change", 32'(change), 32'd0);

        // Brighter-only commit.
        drive(0, 0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0); tick();
        chk("br_pending", 32'(pending), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 1); tick();
        chk("br_brighter", 32'(brighter), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("br_no_change", 32'(change), 32'd0);
            tick();
        end
        chk("br_done", 32'(cfg_busy), 32'd0);

        // Saturation on slot 0, then apply coinciding with frame_end.
        drive(1, 0, 0, 0, 0, 0); tick();
        repeat (5) begin drive(0, 1, 0, 0, 0, 0); tick(); end
        chk("sat_hi", 32'(cur_val), 32'd7);
        repeat (9) begin drive(0, 0, 1, 0, 0, 0); tick(); end
        chk("sat_lo", 32'(cur_val), 32'd0);
        drive(0, 0, 0, 0, 1, 1); tick();
        chk("af_pending", 32'(pending), 32'd1);
        repeat (3) tick();
        chk("af_still_pending", 32'(pending), 32'd1);
        chk("af_no_change", 32'(change), 32'd0);
        drive(0, 0, 0, 0, 0, 1); tick();
        chk("af_change", 32'(change), 32'd1);
        chk("af_sels", 32'(switch_sels), 32'd0);
        chk("af_vals", 32'(switch_vals), 32'd0);
        repeat (12) tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(7) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
                  $urandom_range(19) == 0, $urandom_range(9) == 0, $urandom_range(11) == 0);
            tick();
        end
        repeat (40) tick();

        // Asynchronous reset during the write of slot 2.
        while (m_sel != 2) begin drive(1, 0, 0, 0, 0, 0); tick(); end
        if (m_sh[2] < 7) drive(0, 1, 0, 0, 0, 0); else drive(0, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 1); tick();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (model_change() && m_sels == 2) found = 1;
            else tick();
        end
        chk("slot2_write_reached", 32'(found), 32'd1);
        chk("slot2_change", 32'(change), 32'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_change", 32'(change), 32'd0);
        chk("arst_busy", 32'(cfg_busy), 32'd0);
        chk("arst_sels", 32'(switch_sels), 32'd0);
        chk("arst_cur_val", 32'(cur_val), 32'd4);
        repeat (2) tick();
        #1 reset = 1'b1;
        drive(0, 0, 0, 0, 1, 0); tick();
        chk("arst_dirty_cleared", 32'(cfg_busy), 32'd0);
        drive(0, 0, 0, 0, 0, 1); tick();
        chk("arst_no_commit", 32'(change), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
